// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b engine: one two-stage half-subtractor cell with a registered
// borrow, stepped LSB first over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             bq_reg;

  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;
  logic             borrow_next;
  logic [WIDTH-1:0] acc_next;

  // Stage 1 subtracts the operand bits, stage 2 subtracts the carried-in borrow.
  assign d1          = sa_reg[0] ^ sb_reg[0];
  assign b1          = ~sa_reg[0] & sb_reg[0];
  assign d           = d1 ^ bq_reg;
  assign b2          = ~d1 & bq_reg;
  assign borrow_next = b1 | b2;

  // New difference bit enters at the MSB; after WIDTH steps bit 0 is the LSB.
  assign acc_next = WIDTH'({d, acc_reg} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      bq_reg     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            bq_reg    <= 1'b0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          bq_reg  <= borrow_next;
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            diff       <= acc_next;
            borrow_out <= borrow_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: directed and random operands on an 8-bit and
// a 1-bit instance, compared against plain modular subtraction.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       a1, b1;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;
  logic       busy1, done1, bo1;
  logic [0:0] diff1;

  logic       sel_w1 = 1'b0;
  logic       dn, bs, bo;
  logic [7:0] df;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  assign dn = sel_w1 ? done1 : done8;
  assign bs = sel_w1 ? busy1 : busy8;
  assign bo = sel_w1 ? bo1 : bo8;
  assign df = sel_w1 ? {7'd0, diff1} : diff8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One operation; disturb pulses start mid-run and scrambles the operands.
  task automatic op(input bit w1, input logic [7:0] av, input logic [7:0] bv, input bit disturb);
    int         w;
    int         cyc;
    logic [7:0] mask;
    logic [7:0] exp_d;
    logic       exp_b;
    logic [7:0] prev_d;
    logic       prev_b;
    w      = w1 ? 1 : 8;
    mask   = w1 ? 8'h01 : 8'hFF;
    exp_d  = (av - bv) & mask;
    exp_b  = (av & mask) < (bv & mask);
    sel_w1 = w1;
    #0;
    prev_d = df;
    prev_b = bo;
    if (w1) begin a1 = av[0]; b1 = bv[0]; start1 = 1'b1; end
    else begin a8 = av; b8 = bv; start8 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    cyc = 0;
    while (!dn && cyc < 40) begin
      chk("busy_run", bs, 1);
      chk("diff_held_run", {df, bo}, {prev_d, prev_b});
      if (disturb) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        start8 = (cyc == 2);
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    chk("done_seen", dn, 1);
    chk("latency", cyc, w);
    chk("busy_at_done", bs, 0);
    chk("diff", df, exp_d);
    chk("borrow", bo, exp_b);
    @(negedge clk);
    chk("done_one_cycle", dn, 0);
    chk("diff_hold_after", {df, bo}, {exp_d, exp_b});
    $display("op w=%0d a=%02h b=%02h -> diff=%02h borrow=%0b latency=%0d", w, av, bv, df, bo, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    logic [7:0] last_d;
    logic [7:0] exp_d;
    logic       exp_b;

    rst = 1'b1; start8 = 1'b0; start1 = 1'b0; a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
    #2;
    chk("rst_w8", {busy8, done8, diff8, bo8}, 0);
    chk("rst_w1", {busy1, done1, diff1, bo1}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {busy8, done8, busy1, done1}, 0);

    // Directed cases
    op(1'b0, 8'h5A, 8'h3C, 1'b0);
    op(1'b0, 8'h3C, 8'h5A, 1'b0);
    op(1'b0, 8'h00, 8'h01, 1'b0);
    op(1'b0, 8'hFF, 8'hFF, 1'b0);
    op(1'b0, 8'h81, 8'h7E, 1'b1);

    // Random, some with start pulses and operand changes mid-run
    for (int i = 0; i < 12; i++)
      op(1'b0, 8'($urandom), 8'($urandom), (i % 3) == 0);

    // Start held high: back-to-back operations WIDTH+2 cycles apart
    sel_w1 = 1'b0;
    last_d = diff8;
    a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      exp_d = a8 - b8;
      exp_b = a8 < b8;
      while (!done8 && cyc < 40) begin
        chk("hold_diff", diff8, last_d);
        chk("no_busy_done_overlap", busy8 & done8, 0);
        @(negedge clk);
        cyc++;
      end
      chk("held_done", done8, 1);
      if (k > 0) chk("issue_interval", cyc, 10);
      chk("held_diff", diff8, exp_d);
      chk("held_borrow", bo8, exp_b);
      $display("held op %0d: diff=%02h borrow=%0b interval=%0d", k, diff8, bo8, cyc);
      last_d = exp_d;
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (k == 2) start8 = 1'b0;
      @(negedge clk);
      chk("held_done_single", done8, 0);
      cyc = 1;
    end
    @(negedge clk);
    chk("idle_after_held", {busy8, done8}, 0);

    // Reset during RUN
    op(1'b0, 8'h77, 8'h11, 1'b0);
    a8 = 8'h40; b8 = 8'h05; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", busy8, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {busy8, done8, diff8, bo8}, 0);
    $display("reset mid-run: busy=%0b diff=%02h borrow=%0b", busy8, diff8, bo8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", {busy8, done8}, 0);
    end
    op(1'b0, 8'h10, 8'h01, 1'b0);

    // WIDTH=1 instance, all pairs
    op(1'b1, 8'h00, 8'h00, 1'b0);
    op(1'b1, 8'h00, 8'h01, 1'b0);
    op(1'b1, 8'h01, 8'h00, 1'b0);
    op(1'b1, 8'h01, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++)
      op(1'b1, 8'($urandom_range(1, 0)), 8'($urandom_range(1, 0)), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
